// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: arrival-order pattern view,
// KMP failure table and state-width helper, all evaluated at elaboration.
package seq_det_pkg;

    localparam int MAX_LEN = 32;

    typedef logic [MAX_LEN:0][5:0] fail_arr_t;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Bit i of the result is the i-th bit received (pattern MSB lands in bit 0).
    function automatic logic [63:0] pat_seq(input logic [31:0] pattern, input int len);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < len; i++) begin
            s = s | (64'((pattern >> (len - 1 - i)) & 32'd1) << i);
        end
        return s;
    endfunction

    // f[i] = length of the longest proper prefix of the first i pattern bits
    // that is also a suffix of them.
    function automatic fail_arr_t fail_table(input logic [31:0] pattern, input int len);
        fail_arr_t   f;
        logic [63:0] s;
        logic [5:0]  k;
        logic [5:0]  len6;
        f    = '0;
        s    = pat_seq(pattern, len);
        k    = 6'd0;
        len6 = 6'(len);
        for (logic [5:0] i = 6'd1; i < len6; i++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                if (k != 6'd0 && s[i] != s[k]) k = f[k];
            end
            if (s[i] == s[k]) k = k + 6'd1;
            f[i + 6'd1] = k;
        end
        return f;
    endfunction

endpackage

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector (KMP prefix tracking, registered match pulse).
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_COUNT_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0110,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              clr_i,
    input  logic                              in_valid_i,
    input  logic                              in_i,
    output logic                              match_o,
    output logic [seq_det_pkg::state_w(LEN)-1:0] current_o
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]                  match_count_o
`endif
);

    localparam int          STATE_W = state_w(LEN);
    localparam logic [63:0] PAT_SEQ = pat_seq(32'(PATTERN), LEN);
    localparam fail_arr_t   FAIL    = fail_table(32'(PATTERN), LEN);
    localparam logic [5:0]  LEN6    = 6'(LEN);

    if (LEN < 2 || LEN > MAX_LEN || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_param: LEN must be 2..32 and CNT_W >= 1");
    end

    logic [STATE_W-1:0] current_q, current_d;
    logic               match_q, match_d;
    logic [5:0]         k;
    logic               done;

    always_comb begin
        current_d = current_q;
        match_d   = 1'b0;
        k         = 6'(current_q);
        done      = 1'b0;
        if (clr_i) begin
            current_d = '0;
        end else if (in_valid_i) begin
            // Fail-chain walk; each iteration either extends, stops at 0, or shortens k.
            for (int j = 0; j <= MAX_LEN; j++) begin
                if (!done) begin
                    if (in_i == PAT_SEQ[k]) begin
                        k    = k + 6'd1;
                        done = 1'b1;
                    end else if (k == 6'd0) begin
                        done = 1'b1;
                    end else begin
                        k = FAIL[k];
                    end
                end
            end
            if (k == LEN6) begin
                match_d   = 1'b1;
                current_d = OVERLAP ? STATE_W'(FAIL[LEN6]) : '0;
            end else begin
                current_d = STATE_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            current_q <= '0;
            match_q   <= 1'b0;
        end else begin
            current_q <= current_d;
            match_q   <= match_d;
        end
    end

    assign match_o   = match_q;
    assign current_o = current_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (match_d && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign match_count_o = cnt_q;
`endif

endmodule
